mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences a single shared single-port SRAM between the instruction-fetch port (read-only) and the data-memory port (read/write with byte mask) of the 5-stage pipeline.
- Generates sram_stall, which the hazard detection unit uses to freeze the whole pipeline.
- Each pipeline advance gets at most one data access and one instruction access. Data is served first because it belongs to the older instruction.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- SRAM_LAT, 2, cycles each SRAM access is held; legal range 1..15.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- inst_req  input  1  fetch request, held stable while sram_stall=1.
- inst_addr  input  32  fetch byte address; bits [1:0] ignored.
- inst_rdata  output  32  fetched instruction word.
- dmem_req  input  1  data request, held stable while sram_stall=1.
- dmem_wren  input  1  1=store, 0=load.
- dmem_addr  input  32  data byte address; bits [1:0] ignored.
- dmem_wdata  input  32  store data.
- dmem_bmask  input  4  store byte enables.
- dmem_rdata  output  32  load data.
- sram_stall  output  1  pipeline freeze.
- sram_ce  output  1  SRAM access active.
- sram_we  output  1  SRAM write strobe.
- sram_addr  output  ADDR_W  word address, taken from selected addr[ADDR_W+1:2].
- sram_wdata  output  32  write data.
- sram_bmask  output  4  byte enables; 4'hF on reads.
- sram_rdata  input  32  SRAM read data, valid in the last cycle of an access.

Behaviour:
- FSM states: IDLE, DACC, IACC, DONE. A 4-bit counter cnt tracks cycles within an access.
- IDLE:
  - If dmem_req=1, go to DACC with cnt=0.
  - Else if inst_req=1, go to IACC with cnt=0.
  - Else stay in IDLE.
- DACC:
  - sram_ce=1 and sram_we=dmem_wren.
  - sram_addr, sram_wdata and sram_bmask come from the dmem port.
  - cnt increments each cycle.
  - When cnt==SRAM_LAT-1:
    - If the access is a load, register sram_rdata into dmem_rdata.
    - Next state is IACC (cnt=0) if inst_req=1, otherwise DONE.
- IACC:
  - sram_ce=1, sram_we=0, address from inst_addr.
  - When cnt==SRAM_LAT-1, register sram_rdata into inst_rdata and go to DONE.
- DONE:
  - sram_stall=0; the pipeline advances this cycle and captures inst_rdata/dmem_rdata.
  - Next state is always IDLE.
  - Requests seen in the following IDLE cycle are treated as new.
- sram_stall is combinational: (IDLE && (inst_req || dmem_req)) || DACC || IACC.
- Stall length, with the pipeline advancing in DONE:
  - Data only or instruction only: 1+SRAM_LAT stall cycles.
  - Both: 1+2*SRAM_LAT stall cycles.
  - Neither: 0 stall cycles; FSM stays in IDLE.
- Outside DACC/IACC:
  - sram_ce=0 and sram_we=0.
  - sram_addr, sram_wdata and sram_bmask are 0.
- inst_rdata and dmem_rdata hold their values until overwritten by the next access of the same kind.
- A store never updates dmem_rdata.
- Deassertion of a request mid-access is a protocol violation. The started access still completes; no abort.
- Reset (asynchronous, active-low, legal at any time, including mid-access):
  - State goes to IDLE and cnt to 0.
  - inst_rdata and dmem_rdata go to 0.
  - sram_ce and sram_we go to 0 immediately.
  - sram_stall then follows the IDLE equation.
- Registered outputs change only on a rising i_clk or on reset assertion.

Test Plan:
- Reset, then hold inst_req=1, inst_addr=0x0000_0010, sram_rdata=0x0010_0093 -> sram_stall high for 3 cycles, sram_addr=4, sram_we=0; in the DONE cycle inst_rdata=0x0010_0093 and sram_stall=0.
- dmem_req=1, dmem_wren=1, dmem_addr=0x20, dmem_wdata=0xDEADBEEF, dmem_bmask=4'b0011, inst_req=0 -> 2 cycles with sram_ce=1, sram_we=1, sram_addr=8, sram_bmask=4'b0011; dmem_rdata unchanged; stall high for 3 cycles.
- Load at 0x40 plus fetch at 0x44 requested in the same cycle -> DACC at sram_addr=16 for 2 cycles, then IACC at sram_addr=17 for 2 cycles; stall high for 5 cycles; both data registers correct in DONE.
- SRAM_LAT=1 with back-to-back fetches at 0x0, 0x4, 0x8 -> each fetch gives the pattern stall,stall,release; the IDLE cycle after DONE restarts the sequence with the new address.
- Assert i_rst_n=0 in the second DACC cycle -> sram_ce=0 and sram_we=0 asynchronously, data registers 0; after release with requests still high, a fresh DACC starts from cnt=0.
- inst_req=0 and dmem_req=0 for 10 cycles -> sram_stall=0 and sram_ce=0 throughout; FSM stays in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data memory.
// Data is served before fetch; the pipeline is frozen via sram_stall until DONE.
module mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int SRAM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst_rdata,
  input  logic              dmem_req,
  input  logic              dmem_wren,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic [3:0]        dmem_bmask,
  output logic [31:0]       dmem_rdata,
  output logic              sram_stall,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_bmask,
  input  logic [31:0]       sram_rdata,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, DACC = 2'd1, IACC = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST = 4'(SRAM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_last;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_dmem_rdata;

  assign w_last      = (r_cnt == LAST);
  assign inst_rdata  = r_inst_rdata;
  assign dmem_rdata  = r_dmem_rdata;
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_inst_rdata <= 32'd0;
      r_dmem_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      // SRAM read data is only valid in the final cycle of an access.
      if (r_state == DACC && w_last && !dmem_wren) r_dmem_rdata <= sram_rdata;
      if (r_state == IACC && w_last)               r_inst_rdata <= sram_rdata;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = 4'd0;
        if (dmem_req)      w_next = DACC;
        else if (inst_req) w_next = IACC;
      end
      DACC: begin
        if (w_last) begin
          w_cnt_next = 4'd0;
          w_next     = inst_req ? IACC : DONE;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      IACC: begin
        if (w_last) begin
          w_cnt_next = 4'd0;
          w_next     = DONE;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: begin
        w_cnt_next = 4'd0;
        w_next     = IDLE;
      end
    endcase
  end

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = 32'd0;
    sram_bmask = 4'd0;
    sram_stall = 1'b0;
    case (r_state)
      IDLE: sram_stall = inst_req | dmem_req;
      DACC: begin
        sram_stall = 1'b1;
        sram_ce    = 1'b1;
        sram_we    = dmem_wren;
        sram_addr  = dmem_addr[ADDR_W+1:2];
        sram_wdata = dmem_wdata;
        sram_bmask = dmem_wren ? dmem_bmask : 4'hF;
      end
      IACC: begin
        sram_stall = 1'b1;
        sram_ce    = 1'b1;
        sram_addr  = inst_addr[ADDR_W+1:2];
        sram_bmask = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of the
// stall/access sequence; a second instance runs with a one-cycle SRAM.
module tb_mem_arbiter;
  localparam int AW  = 18;
  localparam int LAT = 2;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          inst_req, dmem_req, dmem_wren;
  logic [31:0]   inst_addr, dmem_addr, dmem_wdata;
  logic [3:0]    dmem_bmask;
  logic [31:0]   inst_rdata, dmem_rdata, sram_wdata, sram_rdata;
  logic          sram_stall, sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_bmask;
  logic [1:0]    dbg_state;

  logic          l1_inst_req;
  logic [31:0]   l1_inst_addr, l1_inst_rdata, l1_dmem_rdata, l1_sram_wdata, l1_sram_rdata;
  logic          l1_sram_stall, l1_sram_ce, l1_sram_we;
  logic [AW-1:0] l1_sram_addr;
  logic [3:0]    l1_sram_bmask;
  logic [1:0]    l1_dbg_state;

  logic [31:0] seed;
  logic        force_en;
  logic [31:0] force_val;

  // SRAM contents: a scrambled function of the word address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (force_en) return force_val;
    return ({14'd0, a} * 32'h9E37_79B1) ^ seed;
  endfunction

  assign sram_rdata    = mem_word(sram_addr);
  assign l1_sram_rdata = mem_word(l1_sram_addr);

  mem_arbiter #(.ADDR_W(AW), .SRAM_LAT(LAT)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .dmem_req(dmem_req), .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_bmask(dmem_bmask), .dmem_rdata(dmem_rdata),
    .sram_stall(sram_stall), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_bmask(sram_bmask),
    .sram_rdata(sram_rdata), .o_dbg_state(dbg_state)
  );

  mem_arbiter #(.ADDR_W(AW), .SRAM_LAT(1)) u_dut_l1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .inst_req(l1_inst_req), .inst_addr(l1_inst_addr), .inst_rdata(l1_inst_rdata),
    .dmem_req(1'b0), .dmem_wren(1'b0), .dmem_addr(32'd0),
    .dmem_wdata(32'd0), .dmem_bmask(4'd0), .dmem_rdata(l1_dmem_rdata),
    .sram_stall(l1_sram_stall), .sram_ce(l1_sram_ce), .sram_we(l1_sram_we),
    .sram_addr(l1_sram_addr), .sram_wdata(l1_sram_wdata), .sram_bmask(l1_sram_bmask),
    .sram_rdata(l1_sram_rdata), .o_dbg_state(l1_dbg_state)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_i, exp_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pipeline advance: requests held from IDLE through DONE.
  task automatic do_txn(input logic dr, input logic wr, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] bm,
                        input logic ir, input logic [31:0] ia);
    logic [AW-1:0] dw, iw;
    dw = da[AW+1:2];
    iw = ia[AW+1:2];
    dmem_req = dr; dmem_wren = wr; dmem_addr = da; dmem_wdata = wd; dmem_bmask = bm;
    inst_req = ir; inst_addr = ia;
    @(negedge i_clk);
    chk("idle_stall", 32'(sram_stall), 32'(dr | ir));
    chk("idle_ce", 32'(sram_ce), 32'd0);
    if (!dr && !ir) begin
      @(posedge i_clk); #1;
      return;
    end
    if (dr) begin
      for (int k = 0; k < LAT; k++) begin
        @(posedge i_clk); @(negedge i_clk);
        chk("d_stall", 32'(sram_stall), 32'd1);
        chk("d_ce", 32'(sram_ce), 32'd1);
        chk("d_we", 32'(sram_we), 32'(wr));
        chk("d_addr", 32'(sram_addr), 32'(dw));
        chk("d_wdata", sram_wdata, wd);
        chk("d_bmask", 32'(sram_bmask), wr ? 32'(bm) : 32'hF);
      end
      if (!wr) exp_d = mem_word(dw);
    end
    if (ir) begin
      for (int k = 0; k < LAT; k++) begin
        @(posedge i_clk); @(negedge i_clk);
        chk("i_stall", 32'(sram_stall), 32'd1);
        chk("i_ce", 32'(sram_ce), 32'd1);
        chk("i_we", 32'(sram_we), 32'd0);
        chk("i_addr", 32'(sram_addr), 32'(iw));
        chk("i_bmask", 32'(sram_bmask), 32'hF);
      end
      exp_i = mem_word(iw);
    end
    @(posedge i_clk); @(negedge i_clk);
    chk("done_stall", 32'(sram_stall), 32'd0);
    chk("done_ce", 32'(sram_ce), 32'd0);
    chk("done_addr", 32'(sram_addr), 32'd0);
    chk("done_inst_rdata", inst_rdata, exp_i);
    chk("done_dmem_rdata", dmem_rdata, exp_d);
    @(posedge i_clk); #1;
  endtask

  task automatic l1_fetch(input logic [31:0] ia);
    l1_inst_req = 1'b1; l1_inst_addr = ia;
    @(negedge i_clk);
    chk("l1_idle_stall", 32'(l1_sram_stall), 32'd1);
    @(posedge i_clk); @(negedge i_clk);
    chk("l1_acc_stall", 32'(l1_sram_stall), 32'd1);
    chk("l1_acc_ce", 32'(l1_sram_ce), 32'd1);
    chk("l1_acc_addr", 32'(l1_sram_addr), 32'(ia[AW+1:2]));
    @(posedge i_clk); @(negedge i_clk);
    chk("l1_done_stall", 32'(l1_sram_stall), 32'd0);
    chk("l1_done_rdata", l1_inst_rdata, mem_word(ia[AW+1:2]));
    @(posedge i_clk); #1;
  endtask

  initial begin
    seed = $urandom; force_en = 1'b0; force_val = 32'd0;
    inst_req = 0; dmem_req = 0; dmem_wren = 0; inst_addr = 0; dmem_addr = 0;
    dmem_wdata = 0; dmem_bmask = 0; l1_inst_req = 0; l1_inst_addr = 0;
    exp_i = 32'd0; exp_d = 32'd0;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    chk("rst_ce", 32'(sram_ce), 32'd0);
    chk("rst_stall", 32'(sram_stall), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // directed cases
    force_en = 1'b1; force_val = 32'h0010_0093;
    do_txn(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0000_0010);
    force_en = 1'b0;
    do_txn(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'd0);
    do_txn(1'b1, 1'b0, 32'h40, 32'd0, 4'd0, 1'b1, 32'h44);

    // reset in the second DACC cycle, requests held through it
    dmem_req = 1'b1; dmem_wren = 1'b0; dmem_addr = 32'h80; inst_req = 1'b1; inst_addr = 32'h84;
    @(posedge i_clk); @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(sram_ce), 32'd0);
    chk("arst_we", 32'(sram_we), 32'd0);
    chk("arst_inst_rdata", inst_rdata, 32'd0);
    chk("arst_dmem_rdata", dmem_rdata, 32'd0);
    chk("arst_stall", 32'(sram_stall), 32'd1);
    exp_i = 32'd0; exp_d = 32'd0;
    #1 i_rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b1, 32'h84);

    // quiet interval
    dmem_req = 1'b0; inst_req = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      chk("quiet_stall", 32'(sram_stall), 32'd0);
      chk("quiet_ce", 32'(sram_ce), 32'd0);
    end
    @(posedge i_clk); #1;

    // one-cycle SRAM, back-to-back fetches
    l1_fetch(32'h0);
    l1_fetch(32'h4);
    l1_fetch(32'h8);
    l1_inst_req = 1'b0;

    // randomized advances
    repeat (60) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
